accum_mult_ctrl: RTL
====================

ACCUM_MULT_CTRL -- requirements
Module: accum_mult_ctrl

Interface
REQ-001 SHALL have parameter BITS, default 1024, operand/result width.
REQ-002 SHALL have parameter RAM_D_W, default 32, reduction-table word width.
REQ-003 SHALL have parameter RAM_WORDS, default 64, table words per load.
REQ-004 SHALL have parameter PIPE, default 9, multiplier latency in cycles.
REQ-005 SHALL have parameter T_W, default 32, iteration-count width.
REQ-006 SHALL have ports, one per line: name, direction, width, meaning.
- i_clk  in  1  clock
- i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- i_tbl_dat  in  RAM_D_W  table word
- i_tbl_val  in  1  table word valid
- o_tbl_rdy  out  1  table word accepted
- i_x  in  BITS  job start value
- i_t  in  T_W  squaring count
- i_val  in  1  job valid
- o_rdy  out  1  job accepted
- o_y  out  BITS  result
- o_val  out  1  result valid
- i_rdy  in  1  result consumer ready
- o_mul_dat_a, o_mul_dat_b  out  BITS  multiplier operands
- o_mul_val  out  1  multiplier issue
- o_mul_rdy  out  1  multiplier pipeline advance
- i_mul_dat  in  BITS  multiplier result
- i_mul_val  in  1  multiplier result valid
- o_ram_d  out  RAM_D_W  table data to multiplier
- o_ram_se  out  1  table shift enable
- o_ram_we  out  1  table commit
- o_err  out  1  watchdog error, sticky until next job

Function
REQ-007 SHALL implement FSM states IDLE, LOAD, COMMIT, ISSUE, WAIT, DONE.
REQ-008 IDLE: o_tbl_rdy=1, o_rdy=1; i_tbl_val -> LOAD (first word consumed); else i_val -> capture i_x, i_t, clear o_err, go ISSUE (or DONE with o_y=i_x if i_t==0).
REQ-009 i_tbl_val and i_val both high in IDLE: table load SHALL win; job not accepted (o_rdy SHALL deassert that cycle).
REQ-010 LOAD: each accepted word drives o_ram_d=i_tbl_dat, o_ram_se=1 same cycle (combinational pass-through); word counter increments; after RAM_WORDS words -> COMMIT.
REQ-011 COMMIT: o_ram_we=1 for exactly one cycle, then IDLE.
REQ-012 ISSUE: o_mul_dat_a=o_mul_dat_b=current value, o_mul_val=1 for one cycle, -> WAIT.
REQ-013 WAIT: on i_mul_val, current value <= i_mul_dat, iteration counter increments; counter==captured T -> DONE, else ISSUE.
REQ-014 i_mul_val outside WAIT SHALL be ignored.
REQ-015 o_mul_rdy SHALL be 1 in ISSUE and WAIT, 0 otherwise.
REQ-016 DONE: o_val=1, o_y=current value held stable until i_rdy; on o_val&&i_rdy -> IDLE.
REQ-017 Iteration latency SHALL be PIPE+1 cycles per squaring (ISSUE + PIPE WAIT cycles); job latency T*(PIPE+1)+1 cycles from acceptance to o_val.
REQ-018 Iteration counter SHALL be T_W bits; i_t = 2^T_W-1 SHALL complete without wrap.
REQ-019 o_tbl_rdy=0 and o_rdy=0 in all states except IDLE/LOAD (o_tbl_rdy=1 in LOAD).

Reset
REQ-020 On i_rst_n low: FSM -> IDLE; counters, o_y, o_err cleared; o_val, o_mul_val, o_ram_se, o_ram_we, o_mul_rdy =0, immediately (async).
REQ-021 Reset mid-LOAD or mid-job SHALL abandon it; partial table not committed (no o_ram_we).

Configuration
REQ-022 Macro ACCUM_MULT_CTRL_WDOG_EN defined: counter in WAIT; no i_mul_val within 2*PIPE cycles -> o_err=1, go DONE with o_y = last value.
REQ-023 Macro undefined: WAIT waits indefinitely; o_err tied 0; no watchdog logic.

Verification (BITS=16, PIPE=9, RAM_WORDS=4, bench multiplier model returns a*b mod 1009 after 9 cycles)
REQ-024 Load words 1,2,3,4 back-to-back -> o_ram_se high 4 cycles with o_ram_d=1..4, then single o_ram_we pulse, back to IDLE.
REQ-025 Job x=3, T=2 -> o_y=81, o_val at cycle 21 after acceptance; T=3 -> o_y=507.
REQ-026 Job x=5, T=0 -> o_y=5 next cycle, o_mul_val never asserted.
REQ-027 i_rdy held low 10 cycles in DONE -> o_y/o_val stable, no new job accepted; i_val+i_tbl_val together in IDLE -> LOAD entered, job not accepted.
REQ-028 WDOG_EN defined, model drops result -> o_err=1 after 18 WAIT cycles, o_val=1; reset mid-WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/accum_mult_ctrl_if.sv
// accum_mult_ctrl_if: bundles the table-load, job, result and multiplier
// signals of accum_mult_ctrl. Clock and reset are not part of the bundle.
//   i_tbl_dat/i_tbl_val/o_tbl_rdy       reduction-table word stream
//   i_x/i_t/i_val/o_rdy                 job request (start value, count)
//   o_y/o_val/i_rdy                     result handshake
//   o_mul_dat_a/b, o_mul_val, o_mul_rdy operand issue to external multiplier
//   i_mul_dat/i_mul_val                 multiplier return
//   o_ram_d/o_ram_se/o_ram_we           table stream into the multiplier
//   o_err                               sticky watchdog error
// slave modport: the controller. master modport: the surrounding logic.
interface accum_mult_ctrl_if #(
  parameter int BITS    = 1024,
  parameter int RAM_D_W = 32,
  parameter int T_W     = 32
);
  logic [RAM_D_W-1:0] i_tbl_dat;
  logic               i_tbl_val;
  logic               o_tbl_rdy;
  logic [BITS-1:0]    i_x;
  logic [T_W-1:0]     i_t;
  logic               i_val;
  logic               o_rdy;
  logic [BITS-1:0]    o_y;
  logic               o_val;
  logic               i_rdy;
  logic [BITS-1:0]    o_mul_dat_a;
  logic [BITS-1:0]    o_mul_dat_b;
  logic               o_mul_val;
  logic               o_mul_rdy;
  logic [BITS-1:0]    i_mul_dat;
  logic               i_mul_val;
  logic [RAM_D_W-1:0] o_ram_d;
  logic               o_ram_se;
  logic               o_ram_we;
  logic               o_err;

  modport slave (
    input  i_tbl_dat, i_tbl_val, i_x, i_t, i_val, i_rdy, i_mul_dat, i_mul_val,
    output o_tbl_rdy, o_rdy, o_y, o_val, o_mul_dat_a, o_mul_dat_b, o_mul_val,
           o_mul_rdy, o_ram_d, o_ram_se, o_ram_we, o_err
  );

  modport master (
    output i_tbl_dat, i_tbl_val, i_x, i_t, i_val, i_rdy, i_mul_dat, i_mul_val,
    input  o_tbl_rdy, o_rdy, o_y, o_val, o_mul_dat_a, o_mul_dat_b, o_mul_val,
           o_mul_rdy, o_ram_d, o_ram_se, o_ram_we, o_err
  );
endinterface

// File: rtl/accum_mult_ctrl.sv
// accum_mult_ctrl: controller for repeated modular squaring on an external
// pipelined multiplier. In IDLE it either streams RAM_WORDS reduction-table
// words into the multiplier (shift, then one commit pulse) or accepts a job
// (x, T) and squares x T times, returning the final value on o_y/o_val.
// Ports: i_clk, i_rst_n (async, active-low) and bus (accum_mult_ctrl_if.slave).
// Optional watchdog: define ACCUM_MULT_CTRL_WDOG_EN to abort a squaring whose
// result has not returned within 2*PIPE WAIT cycles (sets sticky o_err).
module accum_mult_ctrl #(
  parameter int BITS      = 1024,
  parameter int RAM_D_W   = 32,
  parameter int RAM_WORDS = 64,
  parameter int PIPE      = 9,
  parameter int T_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  accum_mult_ctrl_if.slave bus
);

  localparam int WC_W = $clog2(RAM_WORDS + 1);

  typedef enum logic [2:0] {IDLE, LOAD, COMMIT, ISSUE, WAIT, DONE} state_t;

  state_t          state, state_nxt;
  logic [WC_W-1:0] word_cnt;
  logic [BITS-1:0] cur;
  logic [T_W-1:0]  t_cap, iter, iter_inc;
  logic            tbl_take, job_take, mul_take, wd_trip;
  logic            tbl_rdy, rdy, ram_we, mul_val, mul_rdy, val;

`ifdef ACCUM_MULT_CTRL_WDOG_EN
  localparam int WD_W = $clog2(2 * PIPE + 1);
  logic [WD_W-1:0] wd;
  logic            err;
`endif

  always_comb begin
    state_nxt = state;
    tbl_rdy   = 1'b0;
    rdy       = 1'b0;
    ram_we    = 1'b0;
    mul_val   = 1'b0;
    mul_rdy   = 1'b0;
    val       = 1'b0;
    tbl_take  = 1'b0;
    job_take  = 1'b0;
    mul_take  = 1'b0;
    wd_trip   = 1'b0;
    iter_inc  = iter + 1'b1;
    case (state)
      IDLE: begin
        tbl_rdy = 1'b1;
        // a pending table word always takes priority over a job
        rdy     = !bus.i_tbl_val;
        if (bus.i_tbl_val) begin
          tbl_take  = 1'b1;
          state_nxt = (RAM_WORDS == 1) ? COMMIT : LOAD;
        end else if (bus.i_val) begin
          job_take  = 1'b1;
          state_nxt = (bus.i_t == '0) ? DONE : ISSUE;
        end
      end
      LOAD: begin
        tbl_rdy = 1'b1;
        if (bus.i_tbl_val) begin
          tbl_take = 1'b1;
          if (word_cnt == WC_W'(RAM_WORDS - 1)) state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        ram_we    = 1'b1;
        state_nxt = IDLE;
      end
      ISSUE: begin
        mul_val   = 1'b1;
        mul_rdy   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        mul_rdy = 1'b1;
        if (bus.i_mul_val) begin
          mul_take  = 1'b1;
          // iter < t_cap here, so iter_inc cannot wrap even for t_cap = all ones
          state_nxt = (iter_inc == t_cap) ? DONE : ISSUE;
        end
`ifdef ACCUM_MULT_CTRL_WDOG_EN
        else if (wd == WD_W'(2 * PIPE - 1)) begin
          wd_trip   = 1'b1;
          state_nxt = DONE;
        end
`endif
      end
      DONE: begin
        val = 1'b1;
        if (bus.i_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      word_cnt <= '0;
      iter     <= '0;
      cur      <= '0;
    end else begin
      state <= state_nxt;
      if (tbl_take) word_cnt <= (state == IDLE) ? WC_W'(1) : word_cnt + 1'b1;
      if (job_take) begin
        cur  <= bus.i_x;
        iter <= '0;
      end
      if (mul_take) begin
        cur  <= bus.i_mul_dat;
        iter <= iter_inc;
      end
    end
  end

  // captured count is data only; it is rewritten on every accepted job
  always_ff @(posedge i_clk) begin
    if (job_take) t_cap <= bus.i_t;
  end

`ifdef ACCUM_MULT_CTRL_WDOG_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wd  <= '0;
      err <= 1'b0;
    end else begin
      if (state == ISSUE)     wd <= '0;
      else if (state == WAIT) wd <= wd + 1'b1;
      if (job_take)     err <= 1'b0;
      else if (wd_trip) err <= 1'b1;
    end
  end
  assign bus.o_err = err;
`else
  assign bus.o_err = 1'b0;
`endif

  assign bus.o_tbl_rdy   = tbl_rdy;
  assign bus.o_rdy       = rdy;
  assign bus.o_y         = cur;
  assign bus.o_val       = val;
  assign bus.o_mul_dat_a = cur;
  assign bus.o_mul_dat_b = cur;
  assign bus.o_mul_val   = mul_val;
  assign bus.o_mul_rdy   = mul_rdy;
  // table words pass straight through to the multiplier's shift chain
  assign bus.o_ram_d     = bus.i_tbl_dat;
  assign bus.o_ram_se    = tbl_take;
  assign bus.o_ram_we    = ram_we;

endmodule
